fpga_status_led_ctrl: RTL and testbench
=======================================

# fpga_status_led_ctrl

Parametrised board-status indicator for the FPGA top-level wrappers. It replaces the single free-running clock-blink counter and the raw reset/exit LEDs with `NUM_LEDS` independently moded LED channels. Each channel supports steady, blink, heartbeat, exit-status and event-stretch patterns, all under PWM brightness control. It sits in the wrapper next to `x_heep_system`, clocked by the generated clock, and consumes the system's exit signals.

## Interface
- `NUM_LEDS`, 4, number of LED channels (≥1)
- `PRESCALE_WIDTH`, 27, free-running prescaler width (≥4); blink period = 2^PRESCALE_WIDTH cycles
- `PWM_WIDTH`, 4, brightness resolution in bits (≥1)
- `STRETCH_CYCLES`, 5000000, on-time of an event pulse in cycles (≥1)

Ports:
- `clk_i` in 1: single clock; all logic on its rising edge
- `rst_ni` in 1: asynchronous, active-low reset
- `mode_i` in 3*NUM_LEDS: channel k uses bits [3k+2:3k]; 0 OFF, 1 ON, 2 BLINK, 3 HEARTBEAT, 4 EXIT, 5 EVENT; 6 and 7 behave as OFF
- `duty_i` in PWM_WIDTH*NUM_LEDS: per-channel brightness; 0 = off, all-ones = fully on
- `event_i` in NUM_LEDS: per-channel event strobe, level-sampled every cycle
- `exit_valid_i` in 1: program-finished flag from the system
- `exit_value_i` in 32: program exit code
- `clear_i` in 1: clears the exit latch
- `led_o` out NUM_LEDS: registered LED drives
- `heartbeat_o` out 1: prescaler MSB; drop-in for the legacy clock LED
- `exit_latched_o` out 1: an exit has been captured
- `exit_pass_o` out 1: the captured exit code was 0

## Operation
- Prescaler `cnt_q` (PRESCALE_WIDTH bits):
  - increments every cycle and wraps modulo 2^PRESCALE_WIDTH
  - phase = `cnt_q[PW-1:PW-3]`
- PWM counter `pwm_q` (PWM_WIDTH bits) increments every cycle and wraps.
  - `pwm_on_k` = (duty_k == all-ones) OR (`pwm_q` < duty_k)
- Raw pattern per channel:
  - OFF: 0
  - ON: 1
  - BLINK: `cnt_q` MSB
  - HEARTBEAT: 1 when phase == 0 or phase == 2, else 0
  - EXIT: 0 if not latched; 1 if latched and pass; `cnt_q` MSB if latched and fail
  - EVENT: 1 when `stretch_q[k]` != 0
- Output: `led_o[k]` is registered as raw_k AND `pwm_on_k`.
- Exit latch:
  - Capture: when not latched and `exit_valid_i` = 1, set `exit_latched_o` = 1 and `exit_pass_o` = (`exit_value_i` == 0).
  - Once latched, the latch ignores `exit_valid_i` and `exit_value_i` until cleared.
  - `clear_i` = 1 forces latched = 0 and pass = 0. It has priority over a capture in the same cycle.
  - If `exit_valid_i` is still high in the following cycle, the latch recaptures.
- Event stretch, per channel, counter of width clog2(STRETCH_CYCLES+1):
  - `event_i[k]` = 1 loads STRETCH_CYCLES; this retriggers and overrides any decrement.
  - otherwise a nonzero counter decrements by 1; zero holds.
  - Counters run in all modes; only EVENT mode displays them.
- `mode_i`, `duty_i`: sampled every cycle; a change takes effect in the next registered output. No glitch filtering.

## Timing
- Reset values: `led_o` = 0, `heartbeat_o` = 0, `exit_latched_o` = 0, `exit_pass_o` = 0, `cnt_q` = 0, `pwm_q` = 0, all stretch counters = 0.
- Reset deasserted mid-operation: every counter restarts from 0. No latch or stretch state survives.
- `led_o` latency: 1 cycle from the state, `mode_i` and `duty_i` present in cycle t.
- Exit status: `exit_valid_i` high at cycle t → `exit_latched_o` and `exit_pass_o` high at t+1 → EXIT-mode `led_o` at t+2.
- Event: `event_i` at cycle t → `led_o` high during cycles t+2 … t+STRETCH_CYCLES+1 (STRETCH_CYCLES cycles at full duty).
- `heartbeat_o`: first rises 2^(PW-1) cycles after reset release; period 2^PW cycles, 50 % duty.
- HEARTBEAT pattern: two pulses of 2^(PW-3) cycles each, per 2^PW period.

## Test plan
Configuration: PRESCALE_WIDTH=6, PWM_WIDTH=2, STRETCH_CYCLES=5, NUM_LEDS=4, duty=3 unless stated.

- Reset, then release → all outputs 0; `heartbeat_o` rises 32 cycles after release and toggles every 32 cycles thereafter.
- Ch0 BLINK, ch1 HEARTBEAT → `led_o[0]` mirrors `heartbeat_o` delayed by 1 cycle; `led_o[1]` is high for cnt 0–7 and 16–23 (delayed by 1 cycle) and low otherwise.
- Ch2 ON with duty sweep:
  - duty=1 → high 1 cycle in every 4
  - duty=2 → high 2 cycles in every 4
  - duty=3 → constantly high
  - duty=0 → constantly low
- Ch3 EXIT:
  - `exit_valid_i` with value 0 → `exit_latched_o` = `exit_pass_o` = 1 next cycle; LED solid.
  - `clear_i` → both flags 0.
  - value 5 → pass = 0; LED blinks like BLINK.
  - `clear_i` and `exit_valid_i` held high together for one cycle → latch stays 0 that cycle, then recaptures the cycle after `clear_i` drops.
- Ch0 EVENT:
  - single pulse at cycle 10 → `led_o[0]` high during cycles 12–16.
  - second pulse at cycle 13 → high through cycle 19.
- Assert `rst_ni` low during an active stretch, a latched exit, and cnt=40 → all outputs 0 immediately; after release `heartbeat_o` again rises after 32 cycles.

Source files
------------

// File: rtl/fpga_status_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fpga_status_led_ctrl
// Description : Multi-channel board status LED driver with blink, heartbeat,
//               exit-status and event-stretch patterns under PWM brightness.
// Revision    : 1.0
// ============================================================================
module fpga_status_led_ctrl #(
    parameter int NUM_LEDS       = 4,
    parameter int PRESCALE_WIDTH = 27,
    parameter int PWM_WIDTH      = 4,
    parameter int STRETCH_CYCLES = 5000000
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [3*NUM_LEDS-1:0]           mode_i,
    input  logic [PWM_WIDTH*NUM_LEDS-1:0]   duty_i,
    input  logic [NUM_LEDS-1:0]             event_i,
    input  logic                            exit_valid_i,
    input  logic [31:0]                     exit_value_i,
    input  logic                            clear_i,
    output logic [NUM_LEDS-1:0]             led_o,
    output logic                            heartbeat_o,
    output logic                            exit_latched_o,
    output logic                            exit_pass_o
);

    localparam int              SW             = $clog2(STRETCH_CYCLES + 1);
    localparam logic [SW-1:0]   C_STRETCH_LOAD = SW'(STRETCH_CYCLES);

    localparam logic [2:0] C_MODE_OFF   = 3'd0;
    localparam logic [2:0] C_MODE_ON    = 3'd1;
    localparam logic [2:0] C_MODE_BLINK = 3'd2;
    localparam logic [2:0] C_MODE_HEART = 3'd3;
    localparam logic [2:0] C_MODE_EXIT  = 3'd4;
    localparam logic [2:0] C_MODE_EVENT = 3'd5;

    logic [PRESCALE_WIDTH-1:0] r_cnt;
    logic [PWM_WIDTH-1:0]      r_pwm;
    logic                      r_latched;
    logic                      r_pass;
    logic [NUM_LEDS-1:0]       r_led;
    logic [NUM_LEDS-1:0]       w_led_next;

    logic       w_blink;
    logic [2:0] w_phase;
    logic       w_heart;
    logic       w_exit_pat;

    assign w_blink    = r_cnt[PRESCALE_WIDTH-1];
    assign w_phase    = r_cnt[PRESCALE_WIDTH-1 -: 3];
    assign w_heart    = (w_phase == 3'd0) || (w_phase == 3'd2);
    // A failed exit code blinks so it is distinguishable from a solid pass.
    assign w_exit_pat = r_latched & (r_pass | w_blink);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt     <= '0;
            r_pwm     <= '0;
            r_latched <= 1'b0;
            r_pass    <= 1'b0;
            r_led     <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            r_pwm <= r_pwm + 1'b1;
            r_led <= w_led_next;
            if (clear_i) begin
                r_latched <= 1'b0;
                r_pass    <= 1'b0;
            end else if (!r_latched && exit_valid_i) begin
                r_latched <= 1'b1;
                r_pass    <= (exit_value_i == 32'd0);
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_LEDS; k++) begin : g_chan
            logic [2:0]           w_mode;
            logic [PWM_WIDTH-1:0] w_duty;
            logic                 w_pwm_on;
            logic                 w_raw;
            logic [SW-1:0]        r_stretch;

            assign w_mode   = mode_i[3*k +: 3];
            assign w_duty   = duty_i[PWM_WIDTH*k +: PWM_WIDTH];
            assign w_pwm_on = (w_duty == {PWM_WIDTH{1'b1}}) || (r_pwm < w_duty);

            // A new strobe always reloads, so back-to-back events extend the pulse.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_stretch <= '0;
                end else if (event_i[k]) begin
                    r_stretch <= C_STRETCH_LOAD;
                end else if (r_stretch != '0) begin
                    r_stretch <= r_stretch - 1'b1;
                end
            end

            always_comb begin
                w_raw = 1'b0;
                case (w_mode)
                    C_MODE_OFF:   w_raw = 1'b0;
                    C_MODE_ON:    w_raw = 1'b1;
                    C_MODE_BLINK: w_raw = w_blink;
                    C_MODE_HEART: w_raw = w_heart;
                    C_MODE_EXIT:  w_raw = w_exit_pat;
                    C_MODE_EVENT: w_raw = (r_stretch != '0);
                    default:      w_raw = 1'b0;
                endcase
            end

            assign w_led_next[k] = w_raw & w_pwm_on;
        end
    endgenerate

    assign led_o          = r_led;
    assign heartbeat_o    = w_blink;
    assign exit_latched_o = r_latched;
    assign exit_pass_o    = r_pass;

endmodule
`default_nettype wire

// File: tb/tb_fpga_status_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpga_status_led_ctrl
// Description : Self-checking bench for fpga_status_led_ctrl against a
//               cycle-count based reference model.
// Revision    : 1.0
// ============================================================================
module tb_fpga_status_led_ctrl;

    localparam int NL   = 4;
    localparam int PW   = 6;
    localparam int PWMW = 2;
    localparam int S    = 5;
    localparam int PER  = 1 << PW;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic [3*NL-1:0]   mode = '0;
    logic [PWMW*NL-1:0] duty = '0;
    logic [NL-1:0]     ev = '0;
    logic              exit_valid = 1'b0;
    logic [31:0]       exit_value = '0;
    logic              clear = 1'b0;
    logic [NL-1:0]     led;
    logic              hb;
    logic              latched;
    logic              pass;

    always #5 clk = ~clk;

    fpga_status_led_ctrl #(
        .NUM_LEDS       (NL),
        .PRESCALE_WIDTH (PW),
        .PWM_WIDTH      (PWMW),
        .STRETCH_CYCLES (S)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .mode_i         (mode),
        .duty_i         (duty),
        .event_i        (ev),
        .exit_valid_i   (exit_valid),
        .exit_value_i   (exit_value),
        .clear_i        (clear),
        .led_o          (led),
        .heartbeat_o    (hb),
        .exit_latched_o (latched),
        .exit_pass_o    (pass)
    );

    int compared   = 0;
    int mismatched = 0;

    // Model: cycles since reset release, exit flags, cycle of last event strobe.
    int m_c;
    bit m_latched;
    bit m_pass;
    int m_last_ev [NL];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, m_c);
        end
    endtask

    task automatic model_reset();
        m_c       = 0;
        m_latched = 1'b0;
        m_pass    = 1'b0;
        for (int k = 0; k < NL; k++) m_last_ev[k] = -1000;
    endtask

    function automatic bit exp_raw(input int k, input logic [2:0] m);
        int p;
        bit blink;
        p     = m_c % PER;
        blink = (p >= PER / 2);
        case (m)
            3'd1:    return 1'b1;
            3'd2:    return blink;
            3'd3:    return ((p / (PER / 8)) == 0) || ((p / (PER / 8)) == 2);
            3'd4:    return m_latched && (m_pass || blink);
            3'd5:    return ((m_c - m_last_ev[k]) >= 1) && ((m_c - m_last_ev[k]) <= S);
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit exp_pwm(input logic [PWMW-1:0] d);
        return (int'(d) == (1 << PWMW) - 1) || ((m_c % (1 << PWMW)) < int'(d));
    endfunction

    task automatic step();
        logic [NL-1:0] exp_led;
        for (int k = 0; k < NL; k++)
            exp_led[k] = exp_raw(k, mode[3*k +: 3]) & exp_pwm(duty[PWMW*k +: PWMW]);
        @(posedge clk);
        #1;
        if (clear) begin
            m_latched = 1'b0;
            m_pass    = 1'b0;
        end else if (!m_latched && exit_valid) begin
            m_latched = 1'b1;
            m_pass    = (exit_value == 32'd0);
        end
        for (int k = 0; k < NL; k++)
            if (ev[k]) m_last_ev[k] = m_c;
        m_c++;
        check("led", 32'(led), 32'(exp_led));
        check("heartbeat", 32'(hb), 32'((m_c % PER) >= PER / 2));
        check("exit_latched", 32'(latched), 32'(m_latched));
        check("exit_pass", 32'(pass), 32'(m_pass));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_led"}, 32'(led), 32'd0);
        check({tag, "_hb"}, 32'(hb), 32'd0);
        check({tag, "_latched"}, 32'(latched), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd0);
    endtask

    initial begin
        model_reset();
        #22;
        check_all_zero("reset");
        @(negedge clk);
        rst_ni = 1'b1;

        // ch0 BLINK, ch1 HEARTBEAT, ch2 ON, ch3 EXIT, all full duty
        mode = {3'd4, 3'd1, 3'd3, 3'd2};
        duty = '1;
        run(70);

        // duty sweep on ch2
        for (int d = 0; d < 4; d++) begin
            duty[2*PWMW +: PWMW] = PWMW'((d + 1) % 4);
            run(12);
        end
        duty = '1;

        // exit pass, clear, exit fail, clear with valid held
        exit_valid = 1'b1; exit_value = 32'd0; step();
        exit_valid = 1'b0; run(4);
        clear = 1'b1; step();
        clear = 1'b0; run(2);
        exit_valid = 1'b1; exit_value = 32'd5; step();
        exit_valid = 1'b0; exit_value = 32'd0; run(70);
        clear = 1'b1; exit_valid = 1'b1; step();
        clear = 1'b0; step();
        exit_valid = 1'b0; run(3);

        // event stretch on ch0, with a retrigger
        mode[2:0] = 3'd5;
        run(3);
        ev[0] = 1'b1; step();
        ev[0] = 1'b0; run(2);
        ev[0] = 1'b1; step();
        ev[0] = 1'b0; run(10);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            if (i % 16 == 0) begin
                mode = 12'($urandom);
                duty = 8'($urandom);
            end
            ev         = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
            exit_valid = ($urandom_range(0, 15) == 0);
            exit_value = ($urandom_range(0, 1) == 1) ? 32'd0 : $urandom;
            clear      = ($urandom_range(0, 31) == 0);
            step();
        end

        // reset during active stretch, latched exit, cnt=40
        mode = {3'd4, 3'd5, 3'd2, 3'd1};
        duty = '1;
        ev = '0; clear = 1'b0;
        exit_valid = 1'b1; exit_value = 32'd0; step();
        exit_valid = 1'b0;
        for (int i = 0; i < PER && (m_c % PER) != 39; i++) step();
        ev[2] = 1'b1; step();
        ev = '0;
        #2;
        rst_ni = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all_zero("held_reset");
        rst_ni = 1'b1;
        run(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
